// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU encodings, forwarding selects and EX stage state type
package cpu_pkg;

  localparam logic [4:0] ZERO_REG = 5'd0;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MWB = 2'b01,
    FWD_EXM = 2'b10
  } fwd_sel_e;

  // An all-zero value of this struct is a bubble.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  shamt;
    logic        alusrc1;
    logic        alusrc2;
    logic [5:0]  alufun;
    logic        sign;
  } ex_state_t;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - per-operand bypass source select, EX/MEM over MEM/WB
module forward_unit
  import cpu_pkg::*;
(
  input  logic [4:0] src,
  input  logic       exm_regwrite,
  input  logic [4:0] exm_rd,
  input  logic       mwb_regwrite,
  input  logic [4:0] mwb_rd,
  output fwd_sel_e   sel
);

  // A nonzero rd check is enough to keep $0 from ever being bypassed.
  always_comb begin
    sel = FWD_REG;
    if (exm_regwrite && (exm_rd != ZERO_REG) && (exm_rd == src)) begin
      sel = FWD_EXM;
    end else if (mwb_regwrite && (mwb_rd != ZERO_REG) && (mwb_rd == src)) begin
      sel = FWD_MWB;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register, operand forwarding and load-use stall
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            id_rs_data,
  input  logic [31:0]            id_rt_data,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [4:0]             id_rd,
  input  logic [31:0]            id_imm_ext,
  input  logic [4:0]             id_shamt,
  input  logic                   id_alusrc1,
  input  logic                   id_alusrc2,
  input  logic [5:0]             id_alufun,
  input  logic                   id_sign,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   id_memwrite,
  input  logic                   id_valid,
  input  logic                   flush,
  input  logic                   exm_regwrite,
  input  logic [4:0]             exm_rd,
  input  logic [31:0]            exm_data,
  input  logic                   mwb_regwrite,
  input  logic [4:0]             mwb_rd,
  input  logic [31:0]            mwb_data,
  output logic [31:0]            alu_in1,
  output logic [31:0]            alu_in2,
  output logic [5:0]             alu_funct,
  output logic                   alu_sign,
  output logic [4:0]             ex_rd,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic                   ex_memwrite,
  output logic [31:0]            ex_store_data,
  output logic                   ex_valid,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  ex_state_t ex_q;
  ex_state_t id_d;
  fwd_sel_e  sel_a;
  fwd_sel_e  sel_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  assign id_d = '{valid: id_valid, regwrite: id_regwrite, memread: id_memread,
                  memwrite: id_memwrite, rs: id_rs, rt: id_rt, rd: id_rd,
                  rs_data: id_rs_data, rt_data: id_rt_data, imm_ext: id_imm_ext,
                  shamt: id_shamt, alusrc1: id_alusrc1, alusrc2: id_alusrc2,
                  alufun: id_alufun, sign: id_sign};

  // Load in EX whose result the instruction in ID needs: hold ID one cycle.
  assign stall = ex_q.memread && ex_q.valid && (ex_q.rd != ZERO_REG) && id_valid &&
                 ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else if (flush || stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && !flush && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  forward_unit u_fwd_a (
    .src          (ex_q.rs),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .mwb_regwrite (mwb_regwrite),
    .mwb_rd       (mwb_rd),
    .sel          (sel_a)
  );

  forward_unit u_fwd_b (
    .src          (ex_q.rt),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .mwb_regwrite (mwb_regwrite),
    .mwb_rd       (mwb_rd),
    .sel          (sel_b)
  );

  always_comb begin
    fwd_a = ex_q.rs_data;
    case (sel_a)
      FWD_EXM: fwd_a = exm_data;
      FWD_MWB: fwd_a = mwb_data;
      default: fwd_a = ex_q.rs_data;
    endcase
  end

  always_comb begin
    fwd_b = ex_q.rt_data;
    case (sel_b)
      FWD_EXM: fwd_b = exm_data;
      FWD_MWB: fwd_b = mwb_data;
      default: fwd_b = ex_q.rt_data;
    endcase
  end

  assign alu_in1       = ex_q.alusrc1 ? {27'b0, ex_q.shamt} : fwd_a;
  assign alu_in2       = ex_q.alusrc2 ? ex_q.imm_ext : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_funct     = ex_q.alufun;
  assign alu_sign      = ex_q.sign;
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_valid      = ex_q.valid;

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the saturating stall counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ID-side inputs: id_rs_data/id_rt_data (32), id_rs/id_rt/id_rd (5), id_imm_ext (32), id_shamt (5), id_alusrc1 (1, select shamt), id_alusrc2 (1, select imm), id_alufun (6), id_sign (1), id_regwrite (1), id_memread (1), id_memwrite (1), id_valid (1).
REQ-005 SHALL have port flush  input  1  branch/jump kill of the instruction entering EX.
REQ-006 SHALL have forwarding inputs: exm_regwrite (1), exm_rd (5), exm_data (32), mwb_regwrite (1), mwb_rd (5), mwb_data (32).
REQ-007 SHALL have ALU-side outputs: alu_in1 (32), alu_in2 (32), alu_funct (6), alu_sign (1).
REQ-008 SHALL have EX/MEM-side outputs: ex_rd (5), ex_regwrite (1), ex_memread (1), ex_memwrite (1), ex_store_data (32), ex_valid (1).
REQ-009 SHALL have outputs stall (1, hold PC and IF/ID) and stall_count (STALL_CNT_W).

Function
REQ-010 SHALL register all ID-side inputs into EX state on each rising edge when not stalled and not flushed; ID-to-EX latency one cycle.
REQ-011 SHALL assert stall combinationally when ex_memread=1, ex_valid=1, ex_rd!=0 and (ex_rd==id_rs or ex_rd==id_rt), with id_valid=1.
REQ-012 SHALL, on a stall cycle, load a bubble into EX: ex_valid, ex_regwrite, ex_memread, ex_memwrite = 0, all other EX fields 0.
REQ-013 SHALL, when flush=1, load a bubble regardless of stall; flush has priority over stall and over normal capture.
REQ-014 SHALL forward operand A (registered rs) as: exm_data if exm_regwrite=1, exm_rd!=0, exm_rd==rs; else mwb_data if mwb_regwrite=1, mwb_rd!=0, mwb_rd==rs; else registered rs_data.
REQ-015 SHALL forward operand B (registered rt) by the same rule and priority as REQ-014.
REQ-016 SHALL never forward for register 0; a $0 source always yields its registered value (0 from register file).
REQ-017 SHALL drive alu_in1 = {27'b0, shamt} when registered alusrc1=1, else forwarded A.
REQ-018 SHALL drive alu_in2 = registered imm_ext when alusrc2=1, else forwarded B.
REQ-019 SHALL drive ex_store_data = forwarded B irrespective of alusrc2.
REQ-020 SHALL drive alu_funct and alu_sign directly from registered alufun and sign; forwarding paths purely combinational from current-cycle forwarding inputs.
REQ-021 SHALL increment stall_count by 1 on each cycle stall=1 and flush=0, saturating at all-ones.
REQ-022 SHALL produce exactly one bubble per load-use hazard; the stalled ID instruction is captured on the following edge.

Reset
REQ-023 SHALL, when reset=1 at a rising edge, clear all EX state to 0 (alu_funct=6'b000000, alu_sign=0, ex_valid=0, all control 0) and stall_count to 0.
REQ-024 SHALL give reset priority over flush and stall; stall output is 0 the cycle after reset since ex_memread=0.

Structure
REQ-025 SHALL take ALU funct encodings (ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011) and the zero-register constant from shared package cpu_pkg.
REQ-026 SHALL instantiate one sub-module forward_unit (per-operand select: 2'b00 reg, 2'b01 MEM/WB, 2'b10 EX/MEM), used twice.

Verification
REQ-027 SHALL cover EX/MEM forward: exm_regwrite=1, exm_rd=8, exm_data=0x00000005, EX rs=8 -> alu_in1=0x00000005.
REQ-028 SHALL cover double hazard: exm_rd=mwb_rd=9, exm_data=0x11, mwb_data=0x22, rt=9, alusrc2=0 -> alu_in2=0x11.
REQ-029 SHALL cover load-use: EX lw ex_rd=10, ID rs=10 -> stall=1 one cycle, next EX ex_valid=0, following edge EX holds ID instruction, stall_count=1.
REQ-030 SHALL cover flush during stall: flush=1 with load-use hazard -> EX bubble, stall_count unchanged.
REQ-031 SHALL cover shift select: alusrc1=1, shamt=4, rt_data=0x00000003, alufun=SLL -> alu_in1=0x00000004, alu_in2=0x00000003.
REQ-032 SHALL cover $0 write: exm_regwrite=1, exm_rd=0, exm_data=0xFFFFFFFF, rs=0 -> alu_in1=0.
